touch_frame_filter: RTL and testbench
=====================================

Name: touch_frame_filter

Overview:
- Conditioning stage between touchpad_controller and tft_driver: debounces press/release from raw z, averages raw x/y over 2^AVG_LOG2 samples, applies offset/shift calibration and screen clamping.
- Publishes the resulting coordinate only on tft new_frame, so the cursor never tears mid-frame.
- Replaces the ad-hoc combinational latch at top level with a fully registered block.

Parameters:
- Z_THRESH, 256, raw z at or above which a sample counts as touched.
- X_OFFSET, 150, raw x calibration offset.
- Y_OFFSET, 300, raw y calibration offset.
- CAL_SHIFT, 2, right shift applied after offset subtraction.
- AVG_LOG2, 2, log2 of samples per average (4).
- X_MAX, 479, clamp limit for pos_x.
- Y_MAX, 271, clamp limit for pos_y.
- PRESS_COUNT, 3, consecutive touched samples required to enter press.
- RELEASE_COUNT, 3, consecutive untouched samples required to release.

Ports:
- cclk  in  1  system clock (100 MHz domain).
- reset  in  1  asynchronous, active-high reset.
- sample_valid  in  1  one-cycle strobe: touch_x/y/z hold a new conversion.
- touch_x  in  12  raw x.
- touch_y  in  12  raw y.
- touch_z  in  12  raw pressure.
- new_frame  in  1  one-cycle strobe from tft_driver at frame start.
- pos_x  out  10  calibrated, frame-aligned x.
- pos_y  out  9  calibrated, frame-aligned y.
- pos_valid  out  1  one-cycle pulse when pos_x/pos_y update.
- pressed  out  1  debounced press state.

Behaviour:
- Single clock: cclk. Reset: asynchronous, active-high; all registers cleared, independent of cclk.
- Reset values: pos_x=0, pos_y=0, pos_valid=0, pressed=0; state=IDLE; counters, accumulators and pending registers 0; pending flag clear.
- Reset mid-operation: clears immediately; partial averages are discarded, no pos_valid is emitted.
- Inputs are only examined on cycles with sample_valid=1. touched = (touch_z >= Z_THRESH).
- IDLE: a touched sample sets cnt=1 and moves to PRESS_DB. Untouched samples are ignored.
- PRESS_DB: a touched sample increments cnt; the sample making cnt==PRESS_COUNT moves to ACTIVE and clears cnt and the accumulators. An untouched sample returns to IDLE with cnt=0. Debounce samples are never accumulated.
- ACTIVE: a touched sample adds touch_x/touch_y to 14-bit accumulators and increments scnt. An untouched sample sets cnt=1, moves to REL_DB and is not accumulated.
- REL_DB: an untouched sample increments cnt; at cnt==RELEASE_COUNT go to IDLE and clear the accumulators and scnt. A touched sample returns to ACTIVE, is accumulated, and clears cnt.
- pressed is a registered output, 1 in ACTIVE and REL_DB. It changes the cycle after the transitioning sample_valid.
- Average completion: when the accumulated sample makes scnt==2^AVG_LOG2:
  - avg = sum >> AVG_LOG2.
  - cal = 0 if avg < OFFSET, else (avg − OFFSET) >> CAL_SHIFT.
  - cal is clamped to X_MAX/Y_MAX.
  - The result is written to pend_x/pend_y and the pending flag is set on the next cycle.
  - The accumulators and scnt clear for the next window.
  - A newer average overwrites an unconsumed pending value.
- Frame publish: on new_frame=1 with the pending flag set (as registered before this cycle):
  - next cycle, pos_x/pos_y take pend_x/pend_y, pos_valid=1 for exactly one cycle, and the pending flag clears.
  - Without the pending flag, new_frame has no effect.
- Simultaneous events:
  - An average completing in the same cycle as new_frame is not published; it waits for the next new_frame.
  - sample_valid and new_frame in the same cycle are both serviced.
- After release, pos_x/pos_y retain their last values.

Optional Feature:
- Macro TOUCH_FILTER_HYST_EN.
- Defined: while in ACTIVE or REL_DB, touched = (touch_z >= Z_THRESH>>1), giving release hysteresis. Entry from IDLE/PRESS_DB still uses Z_THRESH.
- Undefined: Z_THRESH is used in all states.

Test Plan:
- Press and average: 3 samples x=1150, y=800, z=1000 (→ACTIVE, pressed=1), then 4 more identical samples, then new_frame → pos_x=250, pos_y=125, pos_valid pulses once.
- Glitch reject: 2 samples z=1000 then 1 sample z=100 → state IDLE, pressed stays 0, no pos_valid on subsequent new_frames.
- Clamp and underflow: averaged x=4000, y=100 → pos_x=479, pos_y=0.
- Release debounce: in ACTIVE, samples z=100, 100, 1000 → remains pressed. Then z=100 ×3 → pressed=0, pos_x/pos_y unchanged.
- Frame race: 4th averaged sample's pending update coincident with new_frame → no pos_valid that frame; pos_valid on the following new_frame.
- Hysteresis (macro defined): in ACTIVE, z=200 ×3 → pressed stays 1 and samples accumulate. Without macro → pressed=0.

Source files
------------

// File: rtl/touch_frame_filter.sv
// touch_frame_filter: debounces touch press/release from raw pressure, averages
// raw x/y over 2^AVG_LOG2 samples, applies offset/shift calibration with screen
// clamping, and publishes the coordinate only at tft frame start.
// Optional build macro TOUCH_FILTER_HYST_EN: while pressed, the touch threshold
// drops to Z_THRESH>>1 to give release hysteresis.
module touch_frame_filter #(
  parameter int unsigned Z_THRESH      = 256,
  parameter int unsigned X_OFFSET      = 150,
  parameter int unsigned Y_OFFSET      = 300,
  parameter int unsigned CAL_SHIFT     = 2,
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned X_MAX         = 479,
  parameter int unsigned Y_MAX         = 271,
  parameter int unsigned PRESS_COUNT   = 3,
  parameter int unsigned RELEASE_COUNT = 3
) (
  input  logic        cclk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [11:0] touch_x,
  input  logic [11:0] touch_y,
  input  logic [11:0] touch_z,
  input  logic        new_frame,
  output logic [9:0]  pos_x,
  output logic [8:0]  pos_y,
  output logic        pos_valid,
  output logic        pressed
);

  localparam int unsigned RAW_W   = 12;
  localparam int unsigned ACC_W   = 14;
  localparam int unsigned PX_W    = 10;
  localparam int unsigned PY_W    = 9;
  localparam int unsigned SCNT_W  = AVG_LOG2 + 1;
  localparam int unsigned CNT_MAX = (PRESS_COUNT > RELEASE_COUNT) ? PRESS_COUNT : RELEASE_COUNT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, PRESS_DB, ACTIVE, REL_DB} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [SCNT_W-1:0]  scnt_q, scnt_d, scnt_inc;
  logic [ACC_W-1:0]   acc_x_q, acc_y_q, acc_x_d, acc_y_d, sum_x, sum_y;
  logic [RAW_W-1:0]   z_thresh, avg_x, avg_y, diff_x, diff_y, shr_x, shr_y;
  logic [PX_W-1:0]    cal_x, pend_x_q, pend_x_d, pos_x_d;
  logic [PY_W-1:0]    cal_y, pend_y_q, pend_y_d, pos_y_d;
  logic               pend_q, pend_d, pos_valid_d, pressed_d;
  logic               in_press, touched, accum, win_done, press_done, rel_done, publish;

  assign in_press = (state_q == ACTIVE) || (state_q == REL_DB);

`ifdef TOUCH_FILTER_HYST_EN
  assign z_thresh = in_press ? RAW_W'(Z_THRESH >> 1) : RAW_W'(Z_THRESH);
`else
  assign z_thresh = RAW_W'(Z_THRESH);
`endif

  assign touched    = (touch_z >= z_thresh);
  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign scnt_inc   = scnt_q + SCNT_W'(1);
  assign press_done = sample_valid && touched && (state_q == PRESS_DB) &&
                      (cnt_inc == CNT_W'(PRESS_COUNT));
  assign rel_done   = sample_valid && !touched && (state_q == REL_DB) &&
                      (cnt_inc == CNT_W'(RELEASE_COUNT));
  assign accum      = sample_valid && touched && in_press;
  assign win_done   = accum && (scnt_inc == SCNT_W'(1 << AVG_LOG2));
  assign sum_x      = acc_x_q + ACC_W'(touch_x);
  assign sum_y      = acc_y_q + ACC_W'(touch_y);
  assign avg_x      = RAW_W'(sum_x >> AVG_LOG2);
  assign avg_y      = RAW_W'(sum_y >> AVG_LOG2);
  assign publish    = new_frame && pend_q;

  // State register
  always_ff @(posedge cclk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: only sample_valid cycles move the debounce FSM
  always_comb begin
    state_d = state_q;
    if (sample_valid) begin
      case (state_q)
        IDLE:     if (touched) state_d = PRESS_DB;
        PRESS_DB: if (!touched) state_d = IDLE;
                  else if (press_done) state_d = ACTIVE;
        ACTIVE:   if (!touched) state_d = REL_DB;
        REL_DB:   if (touched) state_d = ACTIVE;
                  else if (rel_done) state_d = IDLE;
      endcase
    end
  end

  // Debounce counter: counts consecutive touched (entry) or untouched (release) samples
  always_comb begin
    cnt_d = cnt_q;
    if (sample_valid) begin
      case (state_q)
        IDLE:     if (touched) cnt_d = CNT_W'(1);
        PRESS_DB: cnt_d = (touched && !press_done) ? cnt_inc : '0;
        ACTIVE:   cnt_d = touched ? '0 : CNT_W'(1);
        REL_DB:   cnt_d = (!touched && !rel_done) ? cnt_inc : '0;
      endcase
    end
  end

  // Averaging window: accumulate touched samples while pressed, restart per window
  always_comb begin
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    scnt_d  = scnt_q;
    if (press_done || rel_done) begin
      acc_x_d = '0;
      acc_y_d = '0;
      scnt_d  = '0;
    end else if (win_done) begin
      acc_x_d = '0;
      acc_y_d = '0;
      scnt_d  = '0;
    end else if (accum) begin
      acc_x_d = sum_x;
      acc_y_d = sum_y;
      scnt_d  = scnt_inc;
    end
  end

  // X calibration: offset removal with underflow to zero, scale, clamp to screen
  always_comb begin
    diff_x = '0;
    shr_x  = '0;
    cal_x  = '0;
    if (avg_x >= RAW_W'(X_OFFSET)) begin
      diff_x = avg_x - RAW_W'(X_OFFSET);
      shr_x  = diff_x >> CAL_SHIFT;
      cal_x  = (shr_x > RAW_W'(X_MAX)) ? PX_W'(X_MAX) : PX_W'(shr_x);
    end
  end

  // Y calibration: offset removal with underflow to zero, scale, clamp to screen
  always_comb begin
    diff_y = '0;
    shr_y  = '0;
    cal_y  = '0;
    if (avg_y >= RAW_W'(Y_OFFSET)) begin
      diff_y = avg_y - RAW_W'(Y_OFFSET);
      shr_y  = diff_y >> CAL_SHIFT;
      cal_y  = (shr_y > RAW_W'(Y_MAX)) ? PY_W'(Y_MAX) : PY_W'(shr_y);
    end
  end

  // Output logic: pending hand-off to frame-aligned position; a fresh average
  // wins over the publish-clear so it waits for the next frame
  always_comb begin
    pos_valid_d = publish;
    pos_x_d     = publish ? pend_x_q : pos_x;
    pos_y_d     = publish ? pend_y_q : pos_y;
    pend_d      = win_done || (pend_q && !publish);
    pend_x_d    = win_done ? cal_x : pend_x_q;
    pend_y_d    = win_done ? cal_y : pend_y_q;
    pressed_d   = (state_d == ACTIVE) || (state_d == REL_DB);
  end

  // Datapath registers: debounce counter and accumulators
  always_ff @(posedge cclk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      scnt_q  <= '0;
      acc_x_q <= '0;
      acc_y_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
    end
  end

  // Output and pending registers
  always_ff @(posedge cclk or posedge reset) begin
    if (reset) begin
      pend_q    <= 1'b0;
      pend_x_q  <= '0;
      pend_y_q  <= '0;
      pos_x     <= '0;
      pos_y     <= '0;
      pos_valid <= 1'b0;
      pressed   <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      pend_x_q  <= pend_x_d;
      pend_y_q  <= pend_y_d;
      pos_x     <= pos_x_d;
      pos_y     <= pos_y_d;
      pos_valid <= pos_valid_d;
      pressed   <= pressed_d;
    end
  end

endmodule

// File: tb/tb_touch_frame_filter.sv
// Testbench for touch_frame_filter: directed scenarios plus randomized traffic
// checked against a streak/queue-based behavioural model.
module tb_touch_frame_filter;

  localparam int Z_THRESH      = 256;
  localparam int X_OFFSET      = 150;
  localparam int Y_OFFSET      = 300;
  localparam int X_MAX         = 479;
  localparam int Y_MAX         = 271;
  localparam int PRESS_COUNT   = 3;
  localparam int RELEASE_COUNT = 3;
  localparam int AVG_N         = 4;
`ifdef TOUCH_FILTER_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  logic        cclk;
  logic        reset;
  logic        sample_valid;
  logic [11:0] touch_x, touch_y, touch_z;
  logic        new_frame;
  logic [9:0]  pos_x;
  logic [8:0]  pos_y;
  logic        pos_valid;
  logic        pressed;

  int n_cmp;
  int n_err;

  // behavioural model state
  bit m_pressed;
  int m_tstreak, m_ustreak;
  int qx[$];
  int qy[$];
  bit m_pend, m_pos_valid;
  int m_pend_x, m_pend_y, m_pos_x, m_pos_y;

  touch_frame_filter dut (
    .cclk         (cclk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .touch_x      (touch_x),
    .touch_y      (touch_y),
    .touch_z      (touch_z),
    .new_frame    (new_frame),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .pos_valid    (pos_valid),
    .pressed      (pressed)
  );

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  function automatic int cal(input int sum, input int off, input int lim);
    int avg;
    int c;
    avg = sum / AVG_N;
    if (avg < off) c = 0;
    else c = (avg - off) / 4;
    if (c > lim) c = lim;
    return c;
  endfunction

  task automatic model_reset();
    m_pressed = 0; m_tstreak = 0; m_ustreak = 0;
    qx.delete(); qy.delete();
    m_pend = 0; m_pos_valid = 0;
    m_pend_x = 0; m_pend_y = 0; m_pos_x = 0; m_pos_y = 0;
  endtask

  task automatic model_step(input bit sv, input int x, input int y, input int z, input bit nf);
    bit publish;
    bit done;
    bit t;
    int th, sx, sy, cx, cy;
    publish = nf && m_pend;
    done = 0; cx = 0; cy = 0;
    if (sv) begin
      th = (HYST && m_pressed) ? Z_THRESH / 2 : Z_THRESH;
      t = (z >= th);
      if (!m_pressed) begin
        if (t) begin
          m_tstreak++;
          if (m_tstreak == PRESS_COUNT) begin
            m_pressed = 1; m_tstreak = 0; m_ustreak = 0;
            qx.delete(); qy.delete();
          end
        end else begin
          m_tstreak = 0;
        end
      end else if (t) begin
        m_ustreak = 0;
        qx.push_back(x); qy.push_back(y);
        if (qx.size() == AVG_N) begin
          sx = 0; sy = 0;
          foreach (qx[i]) begin sx += qx[i]; sy += qy[i]; end
          cx = cal(sx, X_OFFSET, X_MAX);
          cy = cal(sy, Y_OFFSET, Y_MAX);
          done = 1;
          qx.delete(); qy.delete();
        end
      end else begin
        m_ustreak++;
        if (m_ustreak == RELEASE_COUNT) begin
          m_pressed = 0; m_ustreak = 0;
          qx.delete(); qy.delete();
        end
      end
    end
    m_pos_valid = publish;
    if (publish) begin m_pos_x = m_pend_x; m_pos_y = m_pend_y; end
    if (done) begin m_pend = 1; m_pend_x = cx; m_pend_y = cy; end
    else if (publish) m_pend = 0;
  endtask

  // one clock of stimulus; outputs are sampled by callers 1 time unit after the edge
  task automatic step(input logic sv, input logic [11:0] x, input logic [11:0] y,
                      input logic [11:0] z, input logic nf);
    sample_valid = sv; touch_x = x; touch_y = y; touch_z = z; new_frame = nf;
    @(posedge cclk);
    model_step(sv, int'(x), int'(y), int'(z), nf);
    #1;
    sample_valid = 1'b0; new_frame = 1'b0;
  endtask

  task automatic touch_n(input int n, input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
    for (int i = 0; i < n; i++) step(1'b1, x, y, z, 1'b0);
  endtask

  task automatic frame();
    step(1'b0, 12'd0, 12'd0, 12'd0, 1'b1);
  endtask

  task automatic apply_reset();
    @(negedge cclk);
    reset = 1'b1;
    model_reset();
    @(negedge cclk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    model_reset();
    #2;
    n_cmp++; if (pressed !== 1'b0) begin n_err++; $display("FAIL reset_pressed: got %0b expected 0", pressed); end
    n_cmp++; if (pos_valid !== 1'b0) begin n_err++; $display("FAIL reset_pos_valid: got %0b expected 0", pos_valid); end
    n_cmp++; if (pos_x !== 10'd0) begin n_err++; $display("FAIL reset_pos_x: got %0d expected 0", pos_x); end
    n_cmp++; if (pos_y !== 9'd0) begin n_err++; $display("FAIL reset_pos_y: got %0d expected 0", pos_y); end
    // samples while held in reset are ignored
    sample_valid = 1'b1; touch_x = 12'd1150; touch_y = 12'd800; touch_z = 12'd1000;
    repeat (4) @(posedge cclk);
    #1;
    n_cmp++; if (pressed !== 1'b0) begin n_err++; $display("FAIL reset_hold_pressed: got %0b expected 0", pressed); end
    sample_valid = 1'b0;
    @(negedge cclk);
    reset = 1'b0;
    // build a published value and a partial window, then reset mid-operation
    touch_n(3, 12'd1150, 12'd800, 12'd1000);
    touch_n(4, 12'd1150, 12'd800, 12'd1000);
    frame();
    touch_n(2, 12'd4000, 12'd4000, 12'd1000);
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (pressed !== 1'b0) begin n_err++; $display("FAIL midreset_pressed: got %0b expected 0", pressed); end
    n_cmp++; if (pos_x !== 10'd0) begin n_err++; $display("FAIL midreset_pos_x: got %0d expected 0", pos_x); end
    n_cmp++; if (pos_y !== 9'd0) begin n_err++; $display("FAIL midreset_pos_y: got %0d expected 0", pos_y); end
    @(negedge cclk);
    reset = 1'b0;
    frame();
    n_cmp++; if (pos_valid !== 1'b0) begin n_err++; $display("FAIL midreset_no_publish: got %0b expected 0", pos_valid); end
    touch_n(2, 12'd1150, 12'd800, 12'd1000);
    n_cmp++; if (pressed !== 1'b0) begin n_err++; $display("FAIL midreset_redebounce: got %0b expected 0", pressed); end
    touch_n(1, 12'd1150, 12'd800, 12'd1000);
    touch_n(4, 12'd1150, 12'd800, 12'd1000);
    frame();
    n_cmp++; if (pos_x !== 10'd250) begin n_err++; $display("FAIL midreset_partial_x: got %0d expected 250", pos_x); end
    n_cmp++; if (pos_y !== 9'd125) begin n_err++; $display("FAIL midreset_partial_y: got %0d expected 125", pos_y); end
  endtask

  task automatic test_press_average();
    apply_reset();
    touch_n(2, 12'd1150, 12'd800, 12'd1000);
    n_cmp++; if (pressed !== 1'b0) begin n_err++; $display("FAIL press_early: got %0b expected 0", pressed); end
    touch_n(1, 12'd1150, 12'd800, 12'd1000);
    n_cmp++; if (pressed !== 1'b1) begin n_err++; $display("FAIL press_enter: got %0b expected 1", pressed); end
    frame();
    n_cmp++; if (pos_valid !== 1'b0) begin n_err++; $display("FAIL press_no_pending: got %0b expected 0", pos_valid); end
    touch_n(3, 12'd1150, 12'd800, 12'd1000);
    frame();
    n_cmp++; if (pos_valid !== 1'b0) begin n_err++; $display("FAIL press_partial_window: got %0b expected 0", pos_valid); end
    touch_n(1, 12'd1150, 12'd800, 12'd1000);
    frame();
    n_cmp++; if (pos_valid !== 1'b1) begin n_err++; $display("FAIL press_pos_valid: got %0b expected 1", pos_valid); end
    n_cmp++; if (pos_x !== 10'd250) begin n_err++; $display("FAIL press_pos_x: got %0d expected 250", pos_x); end
    n_cmp++; if (pos_y !== 9'd125) begin n_err++; $display("FAIL press_pos_y: got %0d expected 125", pos_y); end
    frame();
    n_cmp++; if (pos_valid !== 1'b0) begin n_err++; $display("FAIL press_single_pulse: got %0b expected 0", pos_valid); end
    n_cmp++; if (pos_x !== 10'd250) begin n_err++; $display("FAIL press_hold_x: got %0d expected 250", pos_x); end
  endtask

  task automatic test_glitch();
    apply_reset();
    touch_n(2, 12'd1150, 12'd800, 12'd1000);
    touch_n(1, 12'd1150, 12'd800, 12'd100);
    n_cmp++; if (pressed !== 1'b0) begin n_err++; $display("FAIL glitch_pressed: got %0b expected 0", pressed); end
    frame();
    n_cmp++; if (pos_valid !== 1'b0) begin n_err++; $display("FAIL glitch_frame1: got %0b expected 0", pos_valid); end
    frame();
    n_cmp++; if (pos_valid !== 1'b0) begin n_err++; $display("FAIL glitch_frame2: got %0b expected 0", pos_valid); end
    touch_n(2, 12'd1150, 12'd800, 12'd1000);
    n_cmp++; if (pressed !== 1'b0) begin n_err++; $display("FAIL glitch_restart: got %0b expected 0", pressed); end
    apply_reset();
    touch_n(3, 12'd1150, 12'd800, 12'd255);
    n_cmp++; if (pressed !== 1'b0) begin n_err++; $display("FAIL thresh_below: got %0b expected 0", pressed); end
    touch_n(3, 12'd1150, 12'd800, 12'd256);
    n_cmp++; if (pressed !== 1'b1) begin n_err++; $display("FAIL thresh_equal: got %0b expected 1", pressed); end
  endtask

  task automatic test_clamp();
    apply_reset();
    touch_n(3, 12'd4000, 12'd100, 12'd1000);
    touch_n(4, 12'd4000, 12'd100, 12'd1000);
    frame();
    n_cmp++; if (pos_valid !== 1'b1) begin n_err++; $display("FAIL clamp_pos_valid: got %0b expected 1", pos_valid); end
    n_cmp++; if (pos_x !== 10'd479) begin n_err++; $display("FAIL clamp_pos_x: got %0d expected 479", pos_x); end
    n_cmp++; if (pos_y !== 9'd0) begin n_err++; $display("FAIL underflow_pos_y: got %0d expected 0", pos_y); end
  endtask

  task automatic test_release();
    apply_reset();
    touch_n(3, 12'd1150, 12'd800, 12'd1000);
    touch_n(4, 12'd1150, 12'd800, 12'd1000);
    frame();
    touch_n(2, 12'd1150, 12'd800, 12'd100);
    n_cmp++; if (pressed !== 1'b1) begin n_err++; $display("FAIL release_two_low: got %0b expected 1", pressed); end
    touch_n(1, 12'd1150, 12'd800, 12'd1000);
    n_cmp++; if (pressed !== 1'b1) begin n_err++; $display("FAIL release_recover: got %0b expected 1", pressed); end
    touch_n(2, 12'd1150, 12'd800, 12'd100);
    n_cmp++; if (pressed !== 1'b1) begin n_err++; $display("FAIL release_second_two: got %0b expected 1", pressed); end
    touch_n(1, 12'd1150, 12'd800, 12'd100);
    n_cmp++; if (pressed !== 1'b0) begin n_err++; $display("FAIL release_done: got %0b expected 0", pressed); end
    n_cmp++; if (pos_x !== 10'd250) begin n_err++; $display("FAIL release_keep_x: got %0d expected 250", pos_x); end
    n_cmp++; if (pos_y !== 9'd125) begin n_err++; $display("FAIL release_keep_y: got %0d expected 125", pos_y); end
    frame();
    n_cmp++; if (pos_valid !== 1'b0) begin n_err++; $display("FAIL release_no_publish: got %0b expected 0", pos_valid); end
  endtask

  task automatic test_frame_race();
    apply_reset();
    touch_n(3, 12'd1550, 12'd1000, 12'd1000);
    touch_n(3, 12'd1550, 12'd1000, 12'd1000);
    step(1'b1, 12'd1550, 12'd1000, 12'd1000, 1'b1);
    n_cmp++; if (pos_valid !== 1'b0) begin n_err++; $display("FAIL race_same_cycle: got %0b expected 0", pos_valid); end
    step(1'b0, 12'd0, 12'd0, 12'd0, 1'b0);
    n_cmp++; if (pos_valid !== 1'b0) begin n_err++; $display("FAIL race_idle: got %0b expected 0", pos_valid); end
    frame();
    n_cmp++; if (pos_valid !== 1'b1) begin n_err++; $display("FAIL race_next_frame: got %0b expected 1", pos_valid); end
    n_cmp++; if (pos_x !== 10'd350) begin n_err++; $display("FAIL race_pos_x: got %0d expected 350", pos_x); end
    n_cmp++; if (pos_y !== 9'd175) begin n_err++; $display("FAIL race_pos_y: got %0d expected 175", pos_y); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    touch_n(3, 12'd1150, 12'd800, 12'd1000);
    touch_n(4, 12'd1150, 12'd800, 12'd1000);
    step(1'b1, 12'd1550, 12'd1000, 12'd1000, 1'b1);
    n_cmp++; if (pos_valid !== 1'b1) begin n_err++; $display("FAIL b2b_both_serviced: got %0b expected 1", pos_valid); end
    n_cmp++; if (pos_x !== 10'd250) begin n_err++; $display("FAIL b2b_first_x: got %0d expected 250", pos_x); end
    touch_n(3, 12'd1550, 12'd1000, 12'd1000);
    touch_n(4, 12'd1150, 12'd800, 12'd1000);
    touch_n(4, 12'd4000, 12'd1000, 12'd1000);
    frame();
    n_cmp++; if (pos_x !== 10'd479) begin n_err++; $display("FAIL b2b_overwrite_x: got %0d expected 479", pos_x); end
    n_cmp++; if (pos_y !== 9'd175) begin n_err++; $display("FAIL b2b_overwrite_y: got %0d expected 175", pos_y); end
    frame();
    n_cmp++; if (pos_valid !== 1'b0) begin n_err++; $display("FAIL b2b_consumed: got %0b expected 0", pos_valid); end
  endtask

  task automatic test_hysteresis();
    logic       exp_p;
    logic [9:0] exp_x;
    apply_reset();
    touch_n(3, 12'd1550, 12'd1000, 12'd1000);
    touch_n(3, 12'd1550, 12'd1000, 12'd200);
    exp_p = HYST;
    n_cmp++; if (pressed !== exp_p) begin n_err++; $display("FAIL hyst_pressed: got %0b expected %0b", pressed, exp_p); end
    touch_n(1, 12'd1550, 12'd1000, 12'd200);
    frame();
    exp_x = HYST ? 10'd350 : 10'd0;
    n_cmp++; if (pos_valid !== exp_p) begin n_err++; $display("FAIL hyst_pos_valid: got %0b expected %0b", pos_valid, exp_p); end
    n_cmp++; if (pos_x !== exp_x) begin n_err++; $display("FAIL hyst_pos_x: got %0d expected %0d", pos_x, exp_x); end
  endtask

  task automatic test_random();
    bit          hold;
    logic        sv, nf;
    logic [11:0] x, y, z;
    int          pick;
    apply_reset();
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) hold = !hold;
      sv = 1'($urandom_range(0, 1));
      nf = ($urandom_range(0, 7) == 0);
      x  = 12'($urandom_range(0, 4095));
      y  = 12'($urandom_range(0, 4095));
      pick = $urandom_range(0, 7);
      if (hold != (pick == 0)) begin
        case ($urandom_range(0, 2))
          0: z = 12'd256;
          1: z = 12'd257;
          default: z = 12'($urandom_range(256, 4095));
        endcase
      end else begin
        case ($urandom_range(0, 4))
          0: z = 12'd255;
          1: z = 12'd128;
          2: z = 12'd127;
          3: z = 12'd0;
          default: z = 12'($urandom_range(0, 255));
        endcase
      end
      step(sv, x, y, z, nf);
      n_cmp++; if (pressed !== logic'(m_pressed)) begin n_err++; $display("FAIL rand_pressed @%0d: got %0b expected %0b", i, pressed, m_pressed); end
      n_cmp++; if (pos_valid !== logic'(m_pos_valid)) begin n_err++; $display("FAIL rand_pos_valid @%0d: got %0b expected %0b", i, pos_valid, m_pos_valid); end
      n_cmp++; if (pos_x !== 10'(m_pos_x)) begin n_err++; $display("FAIL rand_pos_x @%0d: got %0d expected %0d", i, pos_x, m_pos_x); end
      n_cmp++; if (pos_y !== 9'(m_pos_y)) begin n_err++; $display("FAIL rand_pos_y @%0d: got %0d expected %0d", i, pos_y, m_pos_y); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    sample_valid = 1'b0;
    new_frame = 1'b0;
    touch_x = '0; touch_y = '0; touch_z = '0;
    model_reset();
    test_reset();
    test_press_average();
    test_glitch();
    test_clamp();
    test_release();
    test_frame_race();
    test_back_to_back();
    test_hysteresis();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
